// File: rtl/rv32_fetch_ctrl_if.sv
// Fetch-side bus: decode valid/ready handshake plus the combinational ROM port.
// Handshake: an entry transfers on a cycle where out_valid && out_ready are both
// high at the rising edge; out_valid never depends on out_ready.
interface rv32_fetch_ctrl_if;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_fault;
  logic [31:0] imem_addr;
  logic        imem_en;
  logic [31:0] imem_rdata;

  modport master (
    output out_valid, out_pc, out_inst, out_fault, imem_addr, imem_en,
    input  out_ready, imem_rdata
  );

  modport slave (
    input  out_valid, out_pc, out_inst, out_fault, imem_addr, imem_en,
    output out_ready, imem_rdata
  );
endinterface

// File: rtl/rv32_fetch_ctrl.sv
// RV32 instruction-fetch controller: PC sequencing, one ROM read per cycle into a
// small prefetch queue, redirect flush, halt and out-of-range fault handling.
module rv32_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter int          IMEM_DEPTH = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   halt,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  rv32_fetch_ctrl_if.master      bus,
  output logic                   state_dbg
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic {S_RUN = 1'b0, S_FAULT = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [31:0]       fetch_pc_q;
  logic [AW-1:0]     rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]     count_q;
  logic [31:0]       pc_mem   [FIFO_DEPTH];
  logic [31:0]       inst_mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fault_mem;

  logic pop, space, push, in_range;

  assign pop      = (count_q != '0) && bus.out_ready;
  assign space    = (count_q < CW'(FIFO_DEPTH)) || pop;
  assign push     = (state_q == S_RUN) && !halt && !redirect_valid && space;
  assign in_range = fetch_pc_q[31:2] < 30'(IMEM_DEPTH);

  // The ROM is only read for in-range pushes; reset gates it off asynchronously.
  assign bus.imem_en   = rst_n && push && in_range;
  assign bus.imem_addr = fetch_pc_q;

  assign bus.out_valid = (count_q != '0);
  assign bus.out_pc    = pc_mem[rd_ptr_q];
  assign bus.out_inst  = inst_mem[rd_ptr_q];
  assign bus.out_fault = fault_mem[rd_ptr_q];
  assign state_dbg     = (state_q == S_FAULT);

  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = S_RUN;
    end else if (push && !in_range) begin
      state_d = S_FAULT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_RUN;
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q <= state_d;
      if (redirect_valid) begin
        // Flush wins over any simultaneous pop; the popped entry is discarded.
        fetch_pc_q <= {redirect_pc[31:2], 2'b00};
        rd_ptr_q   <= '0;
        wr_ptr_q   <= '0;
        count_q    <= '0;
      end else begin
        if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (push && in_range) fetch_pc_q <= fetch_pc_q + 32'd4;
        case ({push, pop})
          2'b10:   count_q <= count_q + 1'b1;
          2'b01:   count_q <= count_q - 1'b1;
          default: count_q <= count_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pc_mem[i]   <= '0;
        inst_mem[i] <= '0;
      end
      fault_mem <= '0;
    end else if (push) begin
      pc_mem[wr_ptr_q]    <= fetch_pc_q;
      inst_mem[wr_ptr_q]  <= in_range ? bus.imem_rdata : NOP_INST;
      fault_mem[wr_ptr_q] <= !in_range;
    end
  end

endmodule

// File: tb/tb_rv32_fetch_ctrl.sv
// Bench for rv32_fetch_ctrl: directed test-plan steps followed by random traffic,
// all checked against a queue-based reference model of the fetch rules.
module tb_rv32_fetch_ctrl;

  localparam int          DEPTH      = 2;
  localparam int          IMEM_WORDS = 4;
  localparam logic [31:0] RST_PC     = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        halt = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        state_dbg;
  logic [31:0] rom [16];

  rv32_fetch_ctrl_if bus ();

  rv32_fetch_ctrl #(
    .RESET_PC  (RST_PC),
    .FIFO_DEPTH(DEPTH),
    .IMEM_DEPTH(IMEM_WORDS)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .halt          (halt),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .bus           (bus),
    .state_dbg     (state_dbg)
  );

  always #5 clk = ~clk;

  assign bus.imem_rdata = bus.imem_en ? rom[bus.imem_addr[5:2]] : 32'hDEAD_BEEF;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: {fault, pc, inst} per queued entry.
  logic [64:0] exp_q[$];
  logic [31:0] m_pc;
  bit          m_fault;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit in_rom(input logic [31:0] pc);
    return pc[31:2] < 30'(IMEM_WORDS);
  endfunction

  function automatic bit m_push();
    return !m_fault && !halt && !redirect_valid &&
           (exp_q.size() < DEPTH || (exp_q.size() != 0 && bus.out_ready));
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_pc    = RST_PC;
    m_fault = 1'b0;
  endtask

  task automatic check_model();
    logic [64:0] h;
    chk("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      h = exp_q[0];
      chk("out_pc", bus.out_pc, h[63:32]);
      chk("out_inst", bus.out_inst, h[31:0]);
      chk("out_fault", 32'(bus.out_fault), 32'(h[64]));
    end
    chk("imem_en", 32'(bus.imem_en), 32'(m_push() && in_rom(m_pc)));
    chk("imem_addr", bus.imem_addr, m_pc);
    chk("fault_state", 32'(state_dbg), 32'(m_fault));
  endtask

  task automatic model_advance();
    bit p;
    p = m_push();
    if (redirect_valid) begin
      exp_q.delete();
      m_pc    = redirect_pc & ~32'h3;
      m_fault = 1'b0;
    end else begin
      if (exp_q.size() != 0 && bus.out_ready) void'(exp_q.pop_front());
      if (p) begin
        if (in_rom(m_pc)) begin
          exp_q.push_back({1'b0, m_pc, rom[m_pc[5:2]]});
          m_pc = m_pc + 32'd4;
        end else begin
          exp_q.push_back({1'b1, m_pc, 32'h0000_0013});
          m_fault = 1'b1;
        end
      end
    end
  endtask

  task automatic drive(input bit h, input bit r, input bit rv, input logic [31:0] rp);
    halt           = h;
    bus.out_ready  = r;
    redirect_valid = rv;
    redirect_pc    = rp;
    #1;
  endtask

  task automatic cyc();
    check_model();
    model_advance();
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] seq_pc [4];
    logic [31:0] seq_in [4];
    seq_pc = '{32'h0, 32'h4, 32'h8, 32'hC};
    seq_in = '{32'h11, 32'h22, 32'h33, 32'h44};
    for (int i = 0; i < 16; i++) rom[i] = $urandom;
    for (int i = 0; i < 4; i++) rom[i] = seq_in[i];
    model_reset();
    bus.out_ready = 1'b1;
    #2;
    chk("rst_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_pc", bus.out_pc, 32'h0);
    chk("rst_inst", bus.out_inst, 32'h0);
    chk("rst_fault", 32'(bus.out_fault), 32'h0);
    chk("rst_imem_en", 32'(bus.imem_en), 32'h0);
    chk("rst_state", 32'(state_dbg), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Free run from reset, then the out-of-range fault at word IMEM_WORDS.
    drive(0, 1, 0, 0); cyc();
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 0);
      chk("seq_pc", bus.out_pc, seq_pc[i]);
      chk("seq_inst", bus.out_inst, seq_in[i]);
      cyc();
    end
    drive(0, 1, 0, 0);
    chk("flt_pc", bus.out_pc, 32'h10);
    chk("flt_inst", bus.out_inst, 32'h13);
    chk("flt_fault", 32'(bus.out_fault), 32'h1);
    cyc();
    drive(0, 1, 0, 0);
    chk("flt_idle_valid", 32'(bus.out_valid), 32'h0);
    chk("flt_idle_en", 32'(bus.imem_en), 32'h0);
    cyc();
    drive(0, 1, 1, 32'h4); cyc();
    drive(0, 1, 0, 0);
    chk("redir_gap", 32'(bus.out_valid), 32'h0);
    cyc();
    drive(0, 1, 0, 0);
    chk("redir4_pc", bus.out_pc, 32'h4);
    chk("redir4_inst", bus.out_inst, 32'h22);
    chk("redir4_fault", 32'(bus.out_fault), 32'h0);
    cyc();

    // Backpressure: queue saturates, then drains without loss or repeat.
    drive(0, 1, 1, 32'h0); cyc();
    drive(0, 1, 0, 0); cyc();
    repeat (5) begin drive(0, 0, 0, 0); cyc(); end
    drive(0, 0, 0, 0);
    chk("bp_en", 32'(bus.imem_en), 32'h0);
    chk("bp_pc", bus.out_pc, 32'h0);
    cyc();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 0);
      chk("bp_drain_pc", bus.out_pc, seq_pc[i]);
      cyc();
    end

    // Redirect into a full queue with a misaligned target.
    drive(0, 0, 1, 32'h0); cyc();
    repeat (3) begin drive(0, 0, 0, 0); cyc(); end
    drive(0, 1, 1, 32'h9); cyc();
    drive(0, 1, 0, 0);
    chk("flush_valid", 32'(bus.out_valid), 32'h0);
    cyc();
    drive(0, 1, 0, 0);
    chk("flush_pc", bus.out_pc, 32'h8);
    chk("flush_inst", bus.out_inst, 32'h33);
    chk("flush_fault", 32'(bus.out_fault), 32'h0);
    cyc();

    // Halt with a full queue drains it, then fetch resumes in sequence.
    drive(0, 0, 1, 32'h0); cyc();
    repeat (3) begin drive(0, 0, 0, 0); cyc(); end
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 0, 0);
      chk("halt_pc", bus.out_pc, seq_pc[i]);
      chk("halt_en", 32'(bus.imem_en), 32'h0);
      cyc();
    end
    drive(1, 1, 0, 0);
    chk("halt_empty", 32'(bus.out_valid), 32'h0);
    cyc();
    drive(0, 1, 0, 0);
    chk("resume_addr", bus.imem_addr, 32'h8);
    cyc();
    drive(0, 1, 0, 0);
    chk("resume_pc", bus.out_pc, 32'h8);
    cyc();

    // Asynchronous reset pulse between clock edges.
    drive(0, 1, 1, 32'h4); cyc();
    repeat (2) begin drive(0, 1, 0, 0); cyc(); end
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.out_valid), 32'h0);
    chk("arst_en", 32'(bus.imem_en), 32'h0);
    model_reset();
    #1 rst_n = 1'b1;
    #1 cyc();
    drive(0, 1, 0, 0);
    chk("arst_restart_pc", bus.out_pc, RST_PC);
    cyc();

    // Random traffic against the reference model.
    repeat (400) begin
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 31));
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
